tree_traversal_ctrl: RTL and testbench

- Sequencer for one decision-tree inference: starts at a root address, reads node words from node memory, fetches the selected feature value, and computes the next node address.
- Repeats until a leaf is reached, then reports the class and the traversal depth.
- Sits between the node memory / feature buffer and the inference scheduler, one engine per tree.

---
 rtl/tree_pkg.sv | 47 ++++
 rtl/node_processing.sv | 37 +++
 rtl/tree_traversal_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_tree_traversal_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_pkg.sv
// -----------------------------------------------------------------------------
// tree_pkg
// Shared definitions for the decision-tree traversal engine: node-word field
// positions, datapath widths, the node word as a packed struct and the
// traversal FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package tree_pkg;

  localparam int ADDR_W  = 14;
  localparam int FEAT_W  = 9;
  localparam int FIDX_W  = 8;
  localparam int DEPTH_W = 8;
  localparam int NODE_W  = 32;

  // Node word layout (bit positions)
  localparam int LEAF_BIT  = 0;
  localparam int RIGHT_LSB = 1;
  localparam int RIGHT_MSB = 7;
  localparam int LEFT_LSB  = 8;
  localparam int LEFT_MSB  = 14;
  localparam int CMP_LSB   = 15;
  localparam int CMP_MSB   = 23;
  localparam int FIDX_LSB  = 24;
  localparam int FIDX_MSB  = 31;

  localparam int REL_W = RIGHT_MSB - RIGHT_LSB + 1;
  localparam int CMP_W = CMP_MSB - CMP_LSB + 1;

  // Field order mirrors the bit positions above, MSB first.
  typedef struct packed {
    logic [FIDX_MSB-FIDX_LSB:0]   fidx;
    logic [CMP_MSB-CMP_LSB:0]     cmp;   // class when leaf=1
    logic [LEFT_MSB-LEFT_LSB:0]   left;
    logic [RIGHT_MSB-RIGHT_LSB:0] right;
    logic                         leaf;
  } node_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EVAL,
    DONE
  } state_e;

endpackage

// File: rtl/node_processing.sv
// -----------------------------------------------------------------------------
// node_processing
// Combinational branch decision for one internal tree node: compares the
// fetched feature value against the node's compare value and forms the
// absolute address of the selected child.
// Ports:
//   cmp_i        node compare value
//   left_i       relative offset of the left child
//   right_i      relative offset of the right child
//   cur_addr_i   absolute address of the current node
//   feat_val_i   feature value selected by the node
//   go_left_o    1 when feat_val_i <= cmp_i (unsigned)
//   next_addr_o  cur_addr_i + selected offset, modulo 2^ADDR_W
// -----------------------------------------------------------------------------
module node_processing
  import tree_pkg::*;
(
  input  logic [CMP_W-1:0]  cmp_i,
  input  logic [REL_W-1:0]  left_i,
  input  logic [REL_W-1:0]  right_i,
  input  logic [ADDR_W-1:0] cur_addr_i,
  input  logic [FEAT_W-1:0] feat_val_i,
  output logic              go_left_o,
  output logic [ADDR_W-1:0] next_addr_o
);

  logic [REL_W-1:0] offset;

  always_comb begin
    go_left_o   = (feat_val_i <= cmp_i);
    offset      = go_left_o ? left_i : right_i;
    // Zero-extended add; the carry out of the top bit is dropped so the
    // address wraps around the node memory.
    next_addr_o = cur_addr_i + {{(ADDR_W-REL_W){1'b0}}, offset};
  end

endmodule

// File: rtl/tree_traversal_ctrl.sv
// -----------------------------------------------------------------------------
// tree_traversal_ctrl
// Runs one decision-tree inference: fetches node words starting at a root
// address, evaluates each internal node against the selected feature and
// follows the chosen child until a leaf is reached, then reports the leaf
// class and the number of nodes visited.
//
// Optional feature: define TREE_DEPTH_GUARD_EN to abort a traversal whose
// depth reaches MAX_DEPTH at a non-leaf node (result_err=1, class=0).
// Without it there is no limit and result_err stays 0.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         begin a traversal (accepted only when idle)
//   root_addr     root node address, sampled with start
//   busy          engine not idle
//   mem_rd_en     node-memory read strobe, one per node
//   mem_addr      node-memory read address
//   mem_rd_data   node word, valid MEM_LAT cycles after mem_rd_en
//   feat_idx      feature index of the node being evaluated
//   feat_val      feature value for feat_idx (combinational return)
//   result_valid  one-cycle completion pulse
//   result_class  leaf class, held until overwritten
//   result_depth  nodes visited (leaf included), saturating at 255
//   result_err    depth-guard abort flag
// -----------------------------------------------------------------------------
module tree_traversal_ctrl
  import tree_pkg::*;
#(
  parameter int MEM_LAT   = 1,
  parameter int MAX_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] root_addr,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [NODE_W-1:0] mem_rd_data,
  output logic [FIDX_W-1:0] feat_idx,
  input  logic [FEAT_W-1:0] feat_val,
  output logic              result_valid,
  output logic [CMP_W-1:0]  result_class,
  output logic [DEPTH_W-1:0] result_depth,
  output logic              result_err
);

  localparam int CNT_W = 3;

`ifdef TREE_DEPTH_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  localparam logic [DEPTH_W-1:0] DEPTH_LIMIT = DEPTH_W'(MAX_DEPTH);

  state_e              state_q;
  node_t               node_q;
  logic [ADDR_W-1:0]   cur_addr_q;
  logic [CNT_W-1:0]    lat_cnt_q;
  logic [DEPTH_W-1:0]  depth_q;
  logic [DEPTH_W-1:0]  depth_d;
  logic                busy_q;
  logic                mem_rd_en_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                result_valid_q;
  logic [CMP_W-1:0]    result_class_q;
  logic                result_err_q;

  logic                go_left;
  logic [ADDR_W-1:0]   next_addr;
  logic                depth_limit_hit;

  node_processing u_node_processing (
    .cmp_i       (node_q.cmp),
    .left_i      (node_q.left),
    .right_i     (node_q.right),
    .cur_addr_i  (cur_addr_q),
    .feat_val_i  (feat_val),
    .go_left_o   (go_left),
    .next_addr_o (next_addr)
  );

  // Saturating visit counter; stays at 255 rather than wrapping.
  assign depth_d         = (depth_q == '1) ? depth_q : depth_q + 1'b1;
  // Constant-false when the guard is compiled out.
  assign depth_limit_hit = GUARD_EN && (depth_q == DEPTH_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: reset is synchronous and clears every register, including the node
  // word, so a traversal abandoned by reset leaves no stale state behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      node_q         <= '0;
      cur_addr_q     <= '0;
      lat_cnt_q      <= '0;
      depth_q        <= '0;
      busy_q         <= 1'b0;
      mem_rd_en_q    <= 1'b0;
      mem_addr_q     <= '0;
      result_valid_q <= 1'b0;
      result_class_q <= '0;
      result_err_q   <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a branch below re-asserts them.
      mem_rd_en_q    <= 1'b0;
      result_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            cur_addr_q   <= root_addr;
            depth_q      <= '0;
            result_err_q <= 1'b0;
            busy_q       <= 1'b1;
            mem_rd_en_q  <= 1'b1;
            mem_addr_q   <= root_addr;
            state_q      <= FETCH;
          end
        end

        FETCH: begin
          depth_q   <= depth_d;
          lat_cnt_q <= CNT_W'(MEM_LAT);
          state_q   <= WAIT;
        end

        WAIT: begin
          lat_cnt_q <= lat_cnt_q - 1'b1;
          // Count of 1 marks the cycle in which the read data is valid.
          if (lat_cnt_q == CNT_W'(1)) begin
            node_q  <= mem_rd_data;
            state_q <= EVAL;
          end
        end

        EVAL: begin
          if (node_q.leaf) begin
            result_class_q <= node_q.cmp;
            result_valid_q <= 1'b1;
            state_q        <= DONE;
          end else if (depth_limit_hit) begin
            result_err_q   <= 1'b1;
            result_class_q <= '0;
            result_valid_q <= 1'b1;
            state_q        <= DONE;
          end else begin
            cur_addr_q  <= next_addr;
            mem_addr_q  <= next_addr;
            mem_rd_en_q <= 1'b1;
            state_q     <= FETCH;
          end
        end

        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign mem_rd_en    = mem_rd_en_q;
  assign mem_addr     = mem_addr_q;
  assign feat_idx     = node_q.fidx;
  assign result_valid = result_valid_q;
  assign result_class = result_class_q;
  assign result_depth = depth_q;
  assign result_err   = result_err_q;

endmodule

// File: tb/tb_tree_traversal_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tree_traversal_ctrl
// Directed bench for tree_traversal_ctrl with a behavioural node memory of
// configurable latency and a combinational feature table.
// -----------------------------------------------------------------------------
module tb_tree_traversal_ctrl;
  import tree_pkg::*;

  localparam int MEM_LAT   = 1;
  localparam int MAX_DEPTH = 4;
  localparam int LIMIT     = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] root_addr;
  logic              busy;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [NODE_W-1:0] mem_rd_data;
  logic [FIDX_W-1:0] feat_idx;
  logic [FEAT_W-1:0] feat_val;
  logic              result_valid;
  logic [CMP_W-1:0]  result_class;
  logic [DEPTH_W-1:0] result_depth;
  logic              result_err;

  logic [NODE_W-1:0] node_mem [0:(1<<ADDR_W)-1];
  logic [FEAT_W-1:0] feat_mem [0:255];
  logic [NODE_W-1:0] pipe_d [MEM_LAT];
  logic              pipe_v [MEM_LAT];

  logic [ADDR_W-1:0] addr_log [$];
  int                rv_count = 0;
  int                n_checks = 0;
  int                n_errors = 0;
  int                cyc;
  int                rv0;

  tree_traversal_ctrl #(
    .MEM_LAT   (MEM_LAT),
    .MAX_DEPTH (MAX_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .root_addr    (root_addr),
    .busy         (busy),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .feat_idx     (feat_idx),
    .feat_val     (feat_val),
    .result_valid (result_valid),
    .result_class (result_class),
    .result_depth (result_depth),
    .result_err   (result_err)
  );

  always #5 clk = ~clk;

  // Node memory: data valid exactly MEM_LAT cycles after the strobe, all-ones
  // junk otherwise so early or late sampling is visible.
  always @(posedge clk) begin
    pipe_v[0] <= mem_rd_en;
    pipe_d[0] <= node_mem[mem_addr];
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign mem_rd_data = pipe_v[MEM_LAT-1] ? pipe_d[MEM_LAT-1] : '1;
  assign feat_val    = feat_mem[feat_idx];

  // Monitor: record read addresses and count completion pulses.
  always @(negedge clk) begin
    if (mem_rd_en) addr_log.push_back(mem_addr);
    if (result_valid) rv_count++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_node(input logic [7:0] fidx, input logic [8:0] cmp,
                                          input logic [6:0] left, input logic [6:0] right,
                                          input logic leaf);
    return {fidx, cmp, left, right, leaf};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accepting edge, i.e. while the DUT is in FETCH.
  task automatic start_trav(input logic [ADDR_W-1:0] a);
    addr_log.delete();
    root_addr = a;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Cycles from the first FETCH to the result_valid cycle, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!result_valid && n < LIMIT) begin
      tick();
      n++;
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_busy"},   32'(busy), 0);
    check({pfx, "_rd_en"},  32'(mem_rd_en), 0);
    check({pfx, "_addr"},   32'(mem_addr), 0);
    check({pfx, "_fidx"},   32'(feat_idx), 0);
    check({pfx, "_rv"},     32'(result_valid), 0);
    check({pfx, "_class"},  32'(result_class), 0);
    check({pfx, "_depth"},  32'(result_depth), 0);
    check({pfx, "_err"},    32'(result_err), 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) node_mem[i] = '0;
    for (int i = 0; i < 256; i++) feat_mem[i] = '0;
    // Test 1: single leaf, class 37
    node_mem[14'h0010] = mk_node(8'd0, 9'd37, 7'd0, 7'd0, 1'b1);
    // Test 2: cmp=100, left=5, fidx=3, feat=100 -> left to 0x105 (class 7)
    node_mem[14'h0100] = mk_node(8'd3, 9'd100, 7'd5, 7'd9, 1'b0);
    node_mem[14'h0105] = mk_node(8'd0, 9'd7, 7'd0, 7'd0, 1'b1);
    feat_mem[3]        = 9'd100;
    // Test 3: root 0x3FFE, right=4, feat=101 > 100 -> wraps to 0x0002
    node_mem[14'h3FFE] = mk_node(8'd4, 9'd100, 7'd1, 7'd4, 1'b0);
    node_mem[14'h0002] = mk_node(8'd0, 9'h1AB, 7'd0, 7'd0, 1'b1);
    feat_mem[4]        = 9'd101;
    // Test 6: self-looping internal node
    node_mem[14'h0200] = mk_node(8'd0, 9'd0, 7'd0, 7'd0, 1'b0);

    rst = 1'b1; start = 1'b0; root_addr = '0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Test 1
    rv0 = rv_count;
    start_trav(14'h0010);
    check("t1_rd_en", 32'(mem_rd_en), 1);
    check("t1_addr",  32'(mem_addr), 32'h10);
    check("t1_busy",  32'(busy), 1);
    wait_done(cyc);
    check("t1_latency", cyc, 3);
    check("t1_class",   32'(result_class), 37);
    check("t1_depth",   32'(result_depth), 1);
    check("t1_err",     32'(result_err), 0);
    tick();
    check("t1_rv_pulse", 32'(result_valid), 0);
    check("t1_busy_off", 32'(busy), 0);
    check("t1_rv_count", rv_count - rv0, 1);

    // Test 2
    start_trav(14'h0100);
    wait_done(cyc);
    check("t2_latency", cyc, 6);
    check("t2_class",   32'(result_class), 7);
    check("t2_depth",   32'(result_depth), 2);
    tick();
    check("t2_reads",   addr_log.size(), 2);
    check("t2_addr2",   32'(addr_log[1]), 32'h105);
    repeat (3) tick();
    check("t2_hold_depth", 32'(result_depth), 2);
    check("t2_hold_class", 32'(result_class), 7);

    // Test 3
    start_trav(14'h3FFE);
    wait_done(cyc);
    check("t3_latency", cyc, 6);
    check("t3_class",   32'(result_class), 32'h1AB);
    check("t3_depth",   32'(result_depth), 2);
    tick();
    check("t3_addr2",   32'(addr_log[1]), 32'h0002);

    // Test 4: start pulsed during WAIT is ignored
    rv0 = rv_count;
    start_trav(14'h0100);
    tick();
    root_addr = 14'h0010;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    check("t4_busy", 32'(busy), 1);
    wait_done(cyc);
    check("t4_class", 32'(result_class), 7);
    check("t4_depth", 32'(result_depth), 2);
    repeat (4) tick();
    check("t4_rv_count", rv_count - rv0, 1);
    check("t4_reads",    addr_log.size(), 2);
    check("t4_busy_off", 32'(busy), 0);

    // Test 6: self-loop
    rv0 = rv_count;
    start_trav(14'h0200);
`ifdef TREE_DEPTH_GUARD_EN
    wait_done(cyc);
    check("t6_latency", cyc, 12);
    check("t6_err",     32'(result_err), 1);
    check("t6_depth",   32'(result_depth), 4);
    check("t6_class",   32'(result_class), 0);
    tick();
    check("t6_rv_count", rv_count - rv0, 1);
`else
    repeat (1000) tick();
    check("t6_busy",     32'(busy), 1);
    check("t6_rv_count", rv_count - rv0, 0);
    check("t6_depth_sat", 32'(result_depth), 255);
    check("t6_err",      32'(result_err), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif

    // Test 5: reset in WAIT of node 2, stale data must be ignored
    rv0 = rv_count;
    start_trav(14'h0100);
    repeat (4) tick();
    check("t5_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    tick();
    check_idle_outputs("t5_rst");
    rst = 1'b0;
    repeat (4) tick();
    check("t5_busy_post", 32'(busy), 0);
    check("t5_rv_count",  rv_count - rv0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
